rr_mux_reg: RTL and testbench
=============================

RR_MUX_REG -- requirements
Module: rr_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per channel (1..64).
REQ-002 SHALL have parameter NCH, default 4, input channel count, power of two, 2..8.
REQ-003 SHALL derive localparam PTRW = log2(NCH), channel-index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NCH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  bit i = channel i offers a beat.
REQ-008 in_ready  output  NCH  bit i = channel i beat accepted this cycle.
REQ-009 mode  input  1  0 = round-robin arbitration, 1 = fixed priority (channel 0 highest).
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_ch  output  PTRW  index of channel that supplied out_data.
REQ-012 out_valid  output  1  output register holds a beat.
REQ-013 out_ready  input  1  downstream accepts beat.

Function
REQ-014 SHALL hold one output beat (out_data, out_ch, out_valid) plus round-robin pointer ptr (PTRW bits); no other storage.
REQ-015 SHALL define load_en = !out_valid || out_ready (combinational).
REQ-016 Grant, mode=0: first channel with in_valid set, searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1.
REQ-017 Grant, mode=1: lowest-index channel with in_valid set; ptr ignored.
REQ-018 in_ready[g] SHALL be 1 only when load_en=1, rst=0, and g is the granted channel; all other bits 0; at most one bit set.
REQ-019 in_ready SHALL NOT depend on in_data; combinational path out_ready -> in_ready permitted.
REQ-020 Transfer on channel g when in_valid[g] && in_ready[g]: next cycle out_data = in_data[g], out_ch = g, out_valid = 1.
REQ-021 On transfer with mode=0: ptr <= (g+1) mod NCH; NCH-1 wraps to 0.
REQ-022 With mode=1, or with no transfer, ptr SHALL hold.
REQ-023 out_valid && out_ready with no new transfer: out_valid <= 0; out_data, out_ch hold.
REQ-024 Drain and load in same cycle: new beat replaces old; sustained throughput one beat/cycle.
REQ-025 out_valid && !out_ready: out_data, out_ch, out_valid SHALL hold unchanged; in_ready all 0.
REQ-026 Latency: input accept at edge N -> out_valid=1 after edge N (visible cycle N+1).
REQ-027 No in_valid bits set: no transfer, ptr holds.
REQ-028 mode change SHALL take effect in same-cycle grant; ptr value retained across mode changes.
REQ-029 Every beat accepted SHALL appear on the output exactly once, in acceptance order; no beat dropped or duplicated.

Reset
REQ-030 rst=1 at an edge: out_valid <= 0, out_data <= 0, out_ch <= 0, ptr <= 0.
REQ-031 While rst=1: in_ready forced all 0; no transfer.
REQ-032 rst mid-operation discards held output beat; first grant after rst starts from channel 0.

Verification
REQ-033 Reset: rst=1 one cycle, in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_ch=0 after edge.
REQ-034 RR fairness: NCH=4, in_valid=4'b1111 held, out_ready=1, mode=0 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 continuously.
REQ-035 Fixed priority: mode=1, in_valid=4'b1010, out_ready=1 -> out_ch=1 every cycle; channel 3 never granted; ptr unchanged.
REQ-036 Backpressure: beat 0xA5A5 from ch2 held with out_ready=0 for 5 cycles -> out_data=0xA5A5, out_ch=2 stable, in_ready=0; out_ready=1 -> drain, next beat loads same cycle.
REQ-037 Wrap/skip: ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2; then in_valid=4'b1001 -> grant ch3, ptr wraps to 0.
REQ-038 Reset mid-stream: out_valid=1 with out_ready=0, rst=1 -> out_valid=0 next cycle; after release, in_valid=4'b1111 grants ch0.

Source files
------------

// File: rtl/rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_reg
// Description : N-channel arbiter (round-robin or fixed priority) feeding a
//               single registered output slot with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_reg #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*WIDTH-1:0]     in_data,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_ready,
    input  logic                     mode,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int PTRW = $clog2(NCH);

    logic [WIDTH-1:0] r_out_data;
    logic [PTRW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [PTRW-1:0]  r_ptr;

    logic [WIDTH-1:0] w_ch_data [NCH];
    logic [PTRW-1:0]  w_start;
    logic [PTRW-1:0]  w_idx;
    logic [PTRW-1:0]  w_gnt;
    logic             w_gnt_found;
    logic             w_load_en;
    logic [NCH-1:0]   w_ready;
    logic             w_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_load_en = !r_out_valid || out_ready;
    assign w_start   = mode ? '0 : r_ptr;

    // Scan from the highest offset down so the closest channel to w_start wins.
    // NCH is a power of two, so the PTRW-bit add wraps modulo NCH for free.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt       = '0;
        w_idx       = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = w_start + PTRW'(k);
            if (in_valid[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt       = w_idx;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_gnt_found && w_load_en && !rst) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    assign w_xfer = |(w_ready & in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_ch_data[w_gnt];
            r_out_ch    <= w_gnt;
            r_out_valid <= 1'b1;
            if (!mode) begin
                r_ptr <= w_gnt + PTRW'(1);
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_reg
// Description : Scenario tasks plus randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_reg;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int PTRW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [WIDTH-1:0]     out_data;
    logic [PTRW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the output slot and the round-robin pointer
    int               m_ptr   = 0;
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_ch    = 0;

    rr_mux_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_grant(logic [NCH-1:0] v, logic md, int p);
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = md ? k : (p + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] model_ready();
        int g;
        logic [NCH-1:0] r;
        r = '0;
        g = model_grant(in_valid, mode, m_ptr);
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_ch(int ch, logic [WIDTH-1:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    // One clock edge; the model follows the transfer rules with the inputs in force.
    task automatic tick();
        int   g;
        logic le;
        g  = model_grant(in_valid, mode, m_ptr);
        le = !m_valid || out_ready;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        end else if (le && g >= 0) begin
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_ch    = g;
            m_valid = 1'b1;
            if (!mode) m_ptr = (g + 1) % NCH;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; out_ready = 1'b0; mode = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b0;
        for (int i = 0; i < NCH; i++) set_ch(i, 16'h1111 * (i + 1));
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d expected 0/0000/0",
                     out_valid, out_data, out_ch);
        end
        rst = 1'b0;
    endtask

    task automatic test_rr_fairness();
        do_reset();
        mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, WIDTH'($urandom));
        for (int i = 0; i < 5; i++) begin
            int exp_ch;
            exp_ch = i % NCH;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_ch !== PTRW'(exp_ch) ||
                out_data !== in_data[exp_ch*WIDTH +: WIDTH]) begin
                n_fail++;
                $display("FAIL rr_fairness[%0d]: got valid=%b ch=%0d data=%h expected 1/%0d/%h",
                         i, out_valid, out_ch, out_data, exp_ch, in_data[exp_ch*WIDTH +: WIDTH]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0010) begin
                n_fail++; $display("FAIL fixed_ready[%0d]: got %b expected 0010", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_ch !== 2'd1 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL fixed_ch[%0d]: got ch=%0d valid=%b expected 1/1", i, out_ch, out_valid);
            end
        end
        // Pointer must still be 0 after fixed-priority grants
        mode = 1'b0; in_valid = 4'b1111;
        tick();
        n_checks++;
        if (out_ch !== 2'd0) begin
            n_fail++; $display("FAIL fixed_ptr_hold: got ch=%0d expected 0", out_ch);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; in_valid = 4'b0100; out_ready = 1'b0;
        set_ch(2, 16'hA5A5);
        tick();
        set_ch(2, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_data !== 16'hA5A5 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got data=%h ch=%0d valid=%b expected a5a5/2/1",
                         i, out_data, out_ch, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 0100", in_ready);
        end
        tick();
        n_checks++;
        if (out_data !== 16'h1234 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reload: got data=%h ch=%0d valid=%b expected 1234/2/1",
                     out_data, out_ch, out_valid);
        end
        in_valid = 4'b0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h1234) begin
            n_fail++; $display("FAIL bp_drain: got valid=%b data=%h expected 0/1234", out_valid, out_data);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        mode = 1'b0; out_ready = 1'b1;
        in_valid = 4'b0100;              // grant ch2 -> pointer 3
        tick();
        in_valid = 4'b0010;
        tick();
        n_checks++;
        if (out_ch !== 2'd1) begin
            n_fail++; $display("FAIL wrap_skip_ch1: got ch=%0d expected 1", out_ch);
        end
        in_valid = 4'b1001;
        tick();
        n_checks++;
        if (out_ch !== 2'd3) begin
            n_fail++; $display("FAIL wrap_skip_ch3: got ch=%0d expected 3", out_ch);
        end
        in_valid = 4'b1111;
        tick();
        n_checks++;
        if (out_ch !== 2'd0) begin
            n_fail++; $display("FAIL wrap_to_0: got ch=%0d expected 0", out_ch);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mode = 1'b0; out_ready = 1'b1; in_valid = 4'b0010;   // pointer -> 2
        tick();
        out_ready = 1'b0; in_valid = 4'b1000;
        tick();
        rst = 1'b1; in_valid = 4'b1111;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_ready: got %b expected 0000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid);
        end
        rst = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_ch !== 2'd0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_first_grant: got ch=%0d valid=%b expected 0/1", out_ch, out_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [NCH-1:0] exp_r;
            rst       = ($urandom_range(0, 49) == 0);
            mode      = ($urandom_range(0, 3) == 0);
            in_valid  = NCH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NCH; i++) set_ch(i, WIDTH'($urandom));
            #1;
            exp_r = model_ready();
            n_checks++;
            if (in_ready !== exp_r) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, exp_r);
            end
            tick();
            n_checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== PTRW'(m_ch)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got valid=%b data=%h ch=%0d expected %b/%h/%0d",
                         c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_wrap_skip();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
